glitch_window_ctrl: RTL and testbench
=====================================

Name: glitch_window_ctrl

Overview:
- Generates the `cnt` glitch-enable strobe consumed by the downstream clock-glitch mux.
- The mux substitutes the fast glitch clock (clk_b) for clk_in1 while `cnt` and its phase qualifiers are high. This block decides on which clk_in1 cycles that substitution is allowed.
- After arming, it waits for an external target trigger, counts a programmable delay, then emits a programmable number of glitch windows of programmable width, separated by a programmable gap.
- Configuration comes from the UART command decoder's register outputs.

Parameters:
- CNT_W, 16, width of the delay, width and gap counters and their config inputs.
- REP_W, 8, width of the repeat-count config input and its counter.
- SYNC_STAGES, 2, number of flops in the trigger synchroniser (minimum 2).

Ports:
- clk_in1  in  1  system clock; same clock that feeds the glitch mux.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse; latches config and enters ARMED.
- abort  in  1  one-cycle pulse; returns to IDLE from any state.
- trigger_in  in  1  asynchronous target trigger, rising-edge sensitive.
- cfg_delay  in  CNT_W  cycles from trigger detection to the first window.
- cfg_width  in  CNT_W  cycles each window is held high.
- cfg_gap  in  CNT_W  low cycles between windows.
- cfg_repeat  in  REP_W  number of windows.
- cnt  out  1  registered glitch-enable; drives mux `cnt`.
- busy  out  1  high in every state except IDLE.
- armed  out  1  high only in ARMED.
- done  out  1  one-cycle pulse when the sequence completes or is aborted.

Behaviour:
- Reset: state=IDLE. cnt, busy, armed, done=0. Synchroniser, edge register and all counters cleared.
- Trigger path:
  - trigger_in passes through SYNC_STAGES flops, then a one-flop edge detector.
  - trig_rise is high in cycle t0 when the synchronised value goes 0->1.
- Config latching:
  - Config is captured on the arm cycle only. Input changes afterwards have no effect until the next arm.
  - Clamps are applied at capture: cfg_repeat=0 -> 1; cfg_gap=0 -> 1.
  - cfg_width=0 means no windows are emitted.
- FSM states and transitions:
  - IDLE: arm -> ARMED.
  - ARMED: trig_rise -> DELAY. The delay counter is loaded with cfg_delay.
  - DELAY: decrements while nonzero. On reaching 0 -> GLITCH, or -> FIN if width=0.
  - GLITCH: cnt=1 for exactly cfg_width cycles. When windows remaining > 1 -> GAP; otherwise -> FIN.
  - GAP: cnt=0 for exactly gap cycles, then -> GLITCH.
  - FIN: done=1 for one cycle, then -> IDLE.
- Timing contract:
  - With delay D, the first cycle with cnt=1 is t0+D+1.
  - Window k (k=0..R-1) starts at t0+D+1+k*(W+G).
  - cnt is driven straight from a flop with no combinational path from inputs, so it cannot glitch at the mux select.
- Ignored events:
  - arm while busy.
  - trig_rise outside ARMED.
  - Further trigger edges during DELAY, GLITCH or GAP.
- abort:
  - Takes priority over every other event in the same cycle.
  - From any non-IDLE state: cnt drops to 0 on the next edge, done pulses once, state -> IDLE.
  - abort in IDLE is a no-op with no done pulse.
- Simultaneous arm and abort in IDLE: abort wins and the block stays in IDLE.
- Counters:
  - All counters are unsigned and saturate at zero; none wraps.
  - Maximum delay is 2^CNT_W-1 cycles.
- Reset asserted mid-sequence drops cnt immediately (asynchronously). No done pulse is produced.

Decomposition:
- Package glitch_pkg holds:
  - the state enum typedef (IDLE, ARMED, DELAY, GLITCH, GAP, FIN);
  - default widths CNT_W and REP_W;
  - a typedef for the packed config struct {delay, width, gap, repeat}.
- Sub-module trig_sync_edge: parameterised SYNC_STAGES synchroniser plus rising-edge detector, producing trig_rise. It is reusable by other trigger consumers.

Test Plan:
1. Reset then arm with D=5, W=3, G=2, R=1; pulse trigger -> cnt high for exactly 3 cycles starting at t0+6; done pulses at the end; busy drops the cycle after done.
2. D=0, W=2, G=4, R=3 -> cnt pattern from t0+1 is 11 0000 11 0000 11, then one done pulse; total cnt-high cycles = 6.
3. Arm with W=0, R=5; trigger -> cnt never rises; done arrives D+1 cycles after t0 plus one FIN cycle.
4. Abort during the second window of R=4 -> cnt=0 on the next edge, one done pulse, and a later trigger produces no cnt activity.
5. Second arm, and extra trigger pulses during DELAY -> no restart, and window timing is identical to scenario 1.
6. Assert rst_n low mid-GLITCH -> cnt=0 asynchronously, no done pulse; after release, a trigger is ignored until the next arm.

Source files
------------

// File: rtl/glitch_window_ctrl_pkg.sv
// Shared types and default widths for the glitch window controller.
package glitch_pkg;
  localparam int CNT_W = 16;
  localparam int REP_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    GLITCH,
    GAP,
    FIN
  } state_e;

  // 'repeat' is a keyword, so the window-count field is named 'repeats'.
  typedef struct packed {
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] gap;
    logic [REP_W-1:0] repeats;
  } cfg_t;
endpackage

// File: rtl/glitch_window_ctrl_if.sv
// Control, config and status bundle between the command decoder and the glitch controller.
interface glitch_window_ctrl_if #(
  parameter int CNT_W = glitch_pkg::CNT_W,
  parameter int REP_W = glitch_pkg::REP_W
);
  logic             arm;
  logic             abort;
  logic             trigger_in;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [REP_W-1:0] cfg_repeat;
  logic             cnt;
  logic             busy;
  logic             armed;
  logic             done;

  modport master (
    output arm, abort, trigger_in, cfg_delay, cfg_width, cfg_gap, cfg_repeat,
    input  cnt, busy, armed, done
  );

  modport slave (
    input  arm, abort, trigger_in, cfg_delay, cfg_width, cfg_gap, cfg_repeat,
    output cnt, busy, armed, done
  );
endinterface

// File: rtl/glitch_window_ctrl_trig_sync_edge.sv
// Multi-flop synchroniser plus rising-edge detect for an asynchronous trigger.
// Latency: o_rise is high SYNC_STAGES cycles after the input is first sampled high; no backpressure.
module trig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/glitch_window_ctrl.sv
// Arm/trigger/delay sequencer producing the registered glitch-enable strobe for the clock mux.
// First window starts delay+1 cycles after the synchronised trigger edge; no backpressure, abort wins.
module glitch_window_ctrl import glitch_pkg::*; #(
  parameter int CNT_W       = glitch_pkg::CNT_W,
  parameter int REP_W       = glitch_pkg::REP_W,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk_in1,
  input logic           rst_n,
  glitch_window_ctrl_if.slave bus
);
  logic             w_trig_rise;
  state_e           r_state;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_ctr;
  logic [REP_W-1:0] r_rep_left;
  logic             r_cnt;
  logic             r_busy;
  logic             r_armed;
  logic             r_done;

  trig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_trig (
    .clk     (clk_in1),
    .rst_n   (rst_n),
    .i_async (bus.trigger_in),
    .o_rise  (w_trig_rise)
  );

  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_delay    <= '0;
      r_width    <= '0;
      r_gap      <= '0;
      r_ctr      <= '0;
      r_rep_left <= '0;
      r_cnt      <= 1'b0;
      r_busy     <= 1'b0;
      r_armed    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        if (r_state != IDLE) begin
          r_state <= IDLE;
          r_cnt   <= 1'b0;
          r_busy  <= 1'b0;
          r_armed <= 1'b0;
          r_done  <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: if (bus.arm) begin
            r_delay    <= bus.cfg_delay;
            r_width    <= bus.cfg_width;
            r_gap      <= (bus.cfg_gap == '0) ? CNT_W'(1) : bus.cfg_gap;
            r_rep_left <= (bus.cfg_repeat == '0) ? REP_W'(1) : bus.cfg_repeat;
            r_state    <= ARMED;
            r_busy     <= 1'b1;
            r_armed    <= 1'b1;
          end
          // Zero delay skips DELAY so the first window still lands at t0+1.
          ARMED: if (w_trig_rise) begin
            r_armed <= 1'b0;
            if (r_delay != '0) begin
              r_state <= DELAY;
              r_ctr   <= r_delay;
            end else if (r_width == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= GLITCH;
              r_cnt   <= 1'b1;
              r_ctr   <= r_width;
            end
          end
          DELAY: begin
            if (r_ctr > CNT_W'(1)) begin
              r_ctr <= r_ctr - CNT_W'(1);
            end else if (r_width == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= GLITCH;
              r_cnt   <= 1'b1;
              r_ctr   <= r_width;
            end
          end
          GLITCH: begin
            if (r_ctr > CNT_W'(1)) begin
              r_ctr <= r_ctr - CNT_W'(1);
            end else if (r_rep_left > REP_W'(1)) begin
              r_state <= GAP;
              r_cnt   <= 1'b0;
              r_ctr   <= r_gap;
            end else begin
              r_state <= FIN;
              r_cnt   <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          GAP: begin
            if (r_ctr > CNT_W'(1)) begin
              r_ctr <= r_ctr - CNT_W'(1);
            end else begin
              r_state    <= GLITCH;
              r_cnt      <= 1'b1;
              r_ctr      <= r_width;
              r_rep_left <= r_rep_left - REP_W'(1);
            end
          end
          FIN: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= 1'b0;
            r_busy  <= 1'b0;
            r_armed <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cnt   = r_cnt;
  assign bus.busy  = r_busy;
  assign bus.armed = r_armed;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_glitch_window_ctrl.sv
// Directed bench: bit i of each trace is the cycle i+1 after the trigger is first driven high.
module tb_glitch_window_ctrl;
  import glitch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [63:0] cnt_tr, done_tr, busy_tr, armed_tr;

  always #5 clk = ~clk;

  glitch_window_ctrl_if #(.CNT_W(16), .REP_W(8)) bus ();

  glitch_window_ctrl #(.CNT_W(16), .REP_W(8), .SYNC_STAGES(2)) dut (
    .clk_in1 (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call just after a negedge; cfg inputs are scrambled afterwards to prove they were latched.
  task automatic arm_cfg(input cfg_t c);
    bus.cfg_delay  = c.delay;
    bus.cfg_width  = c.width;
    bus.cfg_gap    = c.gap;
    bus.cfg_repeat = c.repeats;
    bus.arm        = 1'b1;
    @(negedge clk);
    bus.arm        = 1'b0;
    bus.cfg_delay  = '1;
    bus.cfg_width  = '1;
    bus.cfg_gap    = '1;
    bus.cfg_repeat = '1;
  endtask

  // trig_pat[i] is trigger_in during cycle i; abort_at=i raises abort during cycle i.
  task automatic trace(input int n, input logic [63:0] trig_pat, input int abort_at);
    cnt_tr = '0; done_tr = '0; busy_tr = '0; armed_tr = '0;
    for (int i = 0; i < n; i++) begin
      bus.trigger_in = trig_pat[i];
      bus.abort      = (i == abort_at);
      @(negedge clk);
      cnt_tr[i]   = bus.cnt;
      done_tr[i]  = bus.done;
      busy_tr[i]  = bus.busy;
      armed_tr[i] = bus.armed;
    end
    bus.trigger_in = 1'b0;
    bus.abort      = 1'b0;
  endtask

  initial begin
    bus.arm = 1'b0; bus.abort = 1'b0; bus.trigger_in = 1'b0;
    bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0; bus.cfg_repeat = '0;
    repeat (3) @(negedge clk);
    chk("rst_cnt_async", bus.cnt, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cnt", bus.cnt, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_armed", bus.armed, 1'b0);
    chk("rst_done", bus.done, 1'b0);

    // Arm and abort together in IDLE: abort wins, no done.
    bus.abort = 1'b1;
    arm_cfg('{delay: 16'd1, width: 16'd1, gap: 16'd1, repeats: 8'd1});
    bus.abort = 1'b0;
    chk("armabort_busy", bus.busy, 1'b0);
    chk("armabort_armed", bus.armed, 1'b0);
    chk("armabort_done", bus.done, 1'b0);

    // 1: D=5 W=3 G=2 R=1
    arm_cfg('{delay: 16'd5, width: 16'd3, gap: 16'd2, repeats: 8'd1});
    chk("s1_armed", bus.armed, 1'b1);
    chk("s1_busy", bus.busy, 1'b1);
    trace(16, 64'hF, -1);
    chk("s1_cnt", cnt_tr, 64'h380);
    chk("s1_done", done_tr, 64'h400);
    chk("s1_busy_tr", busy_tr, 64'h7FF);
    chk("s1_armed_tr", armed_tr, 64'h3);

    // 2: D=0 W=2 G=4 R=3 -> 11 0000 11 0000 11 from t0+1
    arm_cfg('{delay: 16'd0, width: 16'd2, gap: 16'd4, repeats: 8'd3});
    trace(20, 64'hF, -1);
    chk("s2_cnt", cnt_tr, 64'hC30C);
    chk("s2_cnt_ones", $countones(cnt_tr), 6);
    chk("s2_done", done_tr, 64'h10000);
    chk("s2_busy_tr", busy_tr, 64'h1FFFF);

    // 3: W=0 R=5 D=3, gap 0 clamped
    arm_cfg('{delay: 16'd3, width: 16'd0, gap: 16'd0, repeats: 8'd5});
    trace(10, 64'hF, -1);
    chk("s3_cnt", cnt_tr, 64'h0);
    chk("s3_done", done_tr, 64'h20);
    chk("s3_busy_tr", busy_tr, 64'h3F);

    // 4: abort in the second of four windows, then an unarmed trigger
    arm_cfg('{delay: 16'd1, width: 16'd3, gap: 16'd2, repeats: 8'd4});
    trace(16, 64'hF, 10);
    chk("s4_cnt", cnt_tr, 64'h338);
    chk("s4_done", done_tr, 64'h400);
    chk("s4_busy_tr", busy_tr, 64'h3FF);
    trace(16, 64'hF, -1);
    chk("s4_post_cnt", cnt_tr, 64'h0);
    chk("s4_post_done", done_tr, 64'h0);

    // 5: re-arm while ARMED is ignored; extra trigger edge lands in DELAY
    arm_cfg('{delay: 16'd5, width: 16'd3, gap: 16'd2, repeats: 8'd1});
    arm_cfg('{delay: 16'd0, width: 16'd7, gap: 16'd1, repeats: 8'd2});
    chk("s5_armed", bus.armed, 1'b1);
    trace(16, 64'h73, -1);
    chk("s5_cnt", cnt_tr, 64'h380);
    chk("s5_done", done_tr, 64'h400);
    chk("s5_busy_tr", busy_tr, 64'h7FF);

    // 6: reset mid-GLITCH drops cnt without an edge
    arm_cfg('{delay: 16'd2, width: 16'd8, gap: 16'd1, repeats: 8'd1});
    trace(6, 64'hF, -1);
    chk("s6_cnt_pre", cnt_tr, 64'h30);
    rst_n = 1'b0;
    #1;
    chk("s6_cnt_async", bus.cnt, 1'b0);
    chk("s6_busy_async", bus.busy, 1'b0);
    chk("s6_done_async", bus.done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    trace(12, 64'hF, -1);
    chk("s6_post_cnt", cnt_tr, 64'h0);
    chk("s6_post_done", done_tr, 64'h0);
    chk("s6_post_busy", busy_tr, 64'h0);
    arm_cfg('{delay: 16'd0, width: 16'd1, gap: 16'd1, repeats: 8'd0});
    trace(6, 64'hF, -1);
    chk("s6_rearm_cnt", cnt_tr, 64'h4);
    chk("s6_rearm_done", done_tr, 64'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
